// File: rtl/ntt_bank_reader_if.sv
// Output stream bundle for ntt_bank_reader: data/last qualified by valid, with ready from the consumer.
interface ntt_bank_reader_if #(
  parameter int unsigned DW = 18
) ();
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ntt_bank_reader.sv
// Sweeps a 2**AW-word bank (1-cycle registered read) in natural or bit-reversed order and streams
// the words out over valid/ready through a 2-entry skid FIFO.
module ntt_bank_reader #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     bitrev_i,
  output logic [AW-1:0]            rd_addr_o,
  input  logic [DW-1:0]            rd_dout_i,
  ntt_bank_reader_if.master        out_if,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic            infl_last_q, infl_last_d;
  logic            done_q, done_d;

  logic [DW-1:0]   fifo_data_q [2];
  logic [1:0]      fifo_last_q;
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      count_q;

  logic            pop, push, issue, cnt_max;
  logic [2:0]      occ;
  logic [AW-1:0]   cnt_rev;

  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < int'(AW); i++) begin
      cnt_rev[i] = cnt_q[int'(AW) - 1 - i];
    end
  end

  assign out_if.out_valid = (count_q != 2'd0);
  assign out_if.out_data  = fifo_data_q[rd_ptr_q];
  assign out_if.out_last  = out_if.out_valid && fifo_last_q[rd_ptr_q];

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push    = inflight_q;
  assign cnt_max = (cnt_q == {AW{1'b1}});

  // Words held plus the one in flight, minus what leaves this cycle, must leave room for one more.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == StRun) && (occ < 3'd2);

  assign rd_addr_o = issue ? (mode_q ? cnt_rev : cnt_q) : '0;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_last_d = issue && cnt_max;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = bitrev_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_max) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_if.out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_dout_i;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
